// File: rtl/uart_pkg.sv
// Shared UART types and helpers, used by both the receive and transmit paths.
package uart_pkg;

  // Parity mode of a frame.
  typedef enum logic [1:0] {
    NONE = 2'd0,
    EVEN = 2'd1,
    ODD  = 2'd2
  } parity_t;

  // Receiver frame states.
  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    START = 3'd1,
    DATA  = 3'd2,
    PAR   = 3'd3,
    STOP  = 3'd4
  } rx_state_t;

  localparam int MAX_DATA_BITS = 9;

  // Parity bit that a correct frame carries for the given data word.
  // Narrower words are zero-extended, which leaves the XOR unchanged.
  function automatic logic calc_parity(input logic [MAX_DATA_BITS-1:0] data,
                                       input parity_t mode);
    logic p;
    p = 1'b0;
    case (mode)
      EVEN:    p = ^data;
      ODD:     p = ~^data;
      default: p = 1'b0;
    endcase
    return p;
  endfunction

endpackage

// File: rtl/uart_baud_gen.sv
// Bit-timing counter for the UART receiver. Fires a sample either at the
// half-bit point (centring on the start bit) or at the full bit period.
module uart_baud_gen #(
  parameter int BAUD_DIV = 2604
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clr_i,
  input  logic half_sel_i,
  output logic sample_o
);

  localparam int CNT_W = $clog2(BAUD_DIV);
  localparam logic [CNT_W-1:0] HALF_LAST = CNT_W'(BAUD_DIV / 2 - 1);
  localparam logic [CNT_W-1:0] FULL_LAST = CNT_W'(BAUD_DIV - 1);

  logic [CNT_W-1:0] cnt_q, cnt_d;

  // Count up; the owner clears on every sample and state change, so the
  // counter never runs past FULL_LAST.
  always_comb begin
    cnt_d = cnt_q + CNT_W'(1);
    if (clr_i) cnt_d = '0;
  end

  // Counter register with synchronous reset.
  always_ff @(posedge clk) begin
    if (!rst_n) cnt_q <= '0;
    else        cnt_q <= cnt_d;
  end

  assign sample_o = half_sel_i ? (cnt_q == HALF_LAST) : (cnt_q == FULL_LAST);

endmodule

// File: rtl/uart_rx_cfg.sv
// Configurable UART receiver: synchroniser, frame FSM, shift register and
// sticky result flags handed to the command layer via rx_rdy / clr_rx_rdy.
//
//  state | meaning
//  ------+-----------------------------------------------------------
//  IDLE  | line idle, waiting for a falling edge on the synced input
//  START | wait half a bit, confirm start bit is still low (else glitch)
//  DATA  | sample DATA_BITS data bits, LSB first
//  PAR   | sample parity bit and record mismatch
//  STOP  | sample STOP_BITS stop bits; a low stop marks a framing error
module uart_rx_cfg
  import uart_pkg::*;
#(
  parameter int      BAUD_DIV  = 2604,
  parameter int      DATA_BITS = 8,
  parameter parity_t PARITY    = NONE,
  parameter int      STOP_BITS = 1
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 RX,
  input  logic                 clr_rx_rdy,
  output logic [DATA_BITS-1:0] rx_data,
  output logic                 rx_rdy,
  output logic                 parity_err,
  output logic                 frame_err,
  output logic                 overrun,
  output logic                 busy
);

  localparam logic [3:0] DATA_LAST = 4'(DATA_BITS - 1);
  localparam logic [3:0] STOP_LAST = 4'(STOP_BITS - 1);

  rx_state_t state_q, state_d;

  logic rx_s1_q, rx_s_q, rx_prev_q;
  logic fall;
  logic sample;
  logic baud_clr;
  logic complete;

  logic [3:0]           bit_cnt_q, bit_cnt_d;
  logic [DATA_BITS-1:0] shift_q, shift_d;
  logic                 par_acc_q, par_acc_d;
  logic                 frm_acc_q, frm_acc_d;

  logic [DATA_BITS-1:0] rx_data_q, rx_data_d;
  logic                 rx_rdy_q, rx_rdy_d;
  logic                 parity_err_q, parity_err_d;
  logic                 frame_err_q, frame_err_d;
  logic                 overrun_q, overrun_d;

  assign fall = ~rx_s_q & rx_prev_q;

  // Counter held at zero while idle so the start-bit half period is measured
  // from the cycle the falling edge is accepted.
  assign baud_clr = (state_q == IDLE) | (state_d != state_q) | sample;

  uart_baud_gen #(
    .BAUD_DIV(BAUD_DIV)
  ) u_baud_gen (
    .clk       (clk),
    .rst_n     (rst_n),
    .clr_i     (baud_clr),
    .half_sel_i(state_q == START),
    .sample_o  (sample)
  );

  // Frame FSM: next state, bit counting, data shift and per-frame error capture.
  always_comb begin
    state_d   = state_q;
    bit_cnt_d = bit_cnt_q;
    shift_d   = shift_q;
    par_acc_d = par_acc_q;
    frm_acc_d = frm_acc_q;
    complete  = 1'b0;
    case (state_q)
      IDLE: begin
        if (fall) begin
          state_d   = START;
          bit_cnt_d = '0;
          par_acc_d = 1'b0;
          frm_acc_d = 1'b0;
        end
      end
      START: begin
        if (sample) begin
          state_d   = rx_s_q ? IDLE : DATA;
          bit_cnt_d = '0;
        end
      end
      DATA: begin
        if (sample) begin
          shift_d = {rx_s_q, shift_q[DATA_BITS-1:1]};
          if (bit_cnt_q == DATA_LAST) begin
            state_d   = (PARITY != NONE) ? PAR : STOP;
            bit_cnt_d = '0;
          end else begin
            bit_cnt_d = bit_cnt_q + 4'd1;
          end
        end
      end
      PAR: begin
        if (sample) begin
          par_acc_d = rx_s_q != calc_parity(MAX_DATA_BITS'(shift_q), PARITY);
          state_d   = STOP;
          bit_cnt_d = '0;
        end
      end
      STOP: begin
        if (sample) begin
          frm_acc_d = frm_acc_q | ~rx_s_q;
          if (bit_cnt_q == STOP_LAST) begin
            state_d  = IDLE;
            complete = 1'b1;
          end else begin
            bit_cnt_d = bit_cnt_q + 4'd1;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Result flags: consumer ack clears them, a completing frame overrides the ack.
  always_comb begin
    rx_data_d    = rx_data_q;
    rx_rdy_d     = rx_rdy_q & ~clr_rx_rdy;
    parity_err_d = parity_err_q & ~clr_rx_rdy;
    frame_err_d  = frame_err_q & ~clr_rx_rdy;
    overrun_d    = overrun_q & ~clr_rx_rdy;
    if (complete) begin
      rx_data_d    = shift_q;
      rx_rdy_d     = 1'b1;
      parity_err_d = par_acc_q;
      frame_err_d  = frm_acc_d;
      overrun_d    = clr_rx_rdy ? 1'b0 : (overrun_q | rx_rdy_q);
    end
  end

  // All state registers; reset aborts any frame in flight.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      rx_s1_q      <= 1'b1;
      rx_s_q       <= 1'b1;
      rx_prev_q    <= 1'b1;
      state_q      <= IDLE;
      bit_cnt_q    <= '0;
      shift_q      <= '0;
      par_acc_q    <= 1'b0;
      frm_acc_q    <= 1'b0;
      rx_data_q    <= '0;
      rx_rdy_q     <= 1'b0;
      parity_err_q <= 1'b0;
      frame_err_q  <= 1'b0;
      overrun_q    <= 1'b0;
    end else begin
      rx_s1_q      <= RX;
      rx_s_q       <= rx_s1_q;
      rx_prev_q    <= rx_s_q;
      state_q      <= state_d;
      bit_cnt_q    <= bit_cnt_d;
      shift_q      <= shift_d;
      par_acc_q    <= par_acc_d;
      frm_acc_q    <= frm_acc_d;
      rx_data_q    <= rx_data_d;
      rx_rdy_q     <= rx_rdy_d;
      parity_err_q <= parity_err_d;
      frame_err_q  <= frame_err_d;
      overrun_q    <= overrun_d;
    end
  end

  assign rx_data    = rx_data_q;
  assign rx_rdy     = rx_rdy_q;
  assign parity_err = parity_err_q;
  assign frame_err  = frame_err_q;
  assign overrun    = overrun_q;
  assign busy       = (state_q != IDLE);

endmodule

// File: tb/tb_uart_rx_cfg.sv
// Bench for uart_rx_cfg: an 8N1 receiver and an 8E2 receiver, driven with
// directed and random frames and compared against a frame-level model.
module tb_uart_rx_cfg;
  import uart_pkg::*;

  localparam int BD   = 16;
  localparam int HALF = BD / 2;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       rx   [2];
  logic       clr  [2];
  logic [7:0] rxd  [2];
  logic       rdy  [2];
  logic       perr [2];
  logic       ferr [2];
  logic       ovr  [2];
  logic       bsy  [2];

  int n_cmp = 0;
  int n_bad = 0;

  // Frame-level reference: what the consumer should currently see.
  logic [7:0] m_data [2];
  logic       m_rdy  [2];
  logic       m_perr [2];
  logic       m_ferr [2];
  logic       m_ovr  [2];

  always #5 clk = ~clk;

  uart_rx_cfg #(.BAUD_DIV(BD), .DATA_BITS(8), .PARITY(NONE), .STOP_BITS(1)) dut_a (
    .clk(clk), .rst_n(rst_n), .RX(rx[0]), .clr_rx_rdy(clr[0]),
    .rx_data(rxd[0]), .rx_rdy(rdy[0]), .parity_err(perr[0]),
    .frame_err(ferr[0]), .overrun(ovr[0]), .busy(bsy[0]));

  uart_rx_cfg #(.BAUD_DIV(BD), .DATA_BITS(8), .PARITY(EVEN), .STOP_BITS(2)) dut_b (
    .clk(clk), .rst_n(rst_n), .RX(rx[1]), .clr_rx_rdy(clr[1]),
    .rx_data(rxd[1]), .rx_rdy(rdy[1]), .parity_err(perr[1]),
    .frame_err(ferr[1]), .overrun(ovr[1]), .busy(bsy[1]));

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic cyc(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  function automatic int has_par(input int s);
    return (s == 1) ? 1 : 0;
  endfunction

  function automatic int n_stop(input int s);
    return (s == 1) ? 2 : 1;
  endfunction

  function automatic int latency(input int s);
    return 2 + HALF + BD * (8 + has_par(s) + n_stop(s)) + 1;
  endfunction

  task automatic model_reset();
    for (int s = 0; s < 2; s++) begin
      m_data[s] = 8'h00;
      m_rdy[s]  = 1'b0;
      m_perr[s] = 1'b0;
      m_ferr[s] = 1'b0;
      m_ovr[s]  = 1'b0;
    end
  endtask

  task automatic check_model(input int s, input string tag);
    chk($sformatf("%s.%0d.data", tag, s), 32'(rxd[s]), 32'(m_data[s]));
    chk($sformatf("%s.%0d.rdy", tag, s), 32'(rdy[s]), 32'(m_rdy[s]));
    chk($sformatf("%s.%0d.perr", tag, s), 32'(perr[s]), 32'(m_perr[s]));
    chk($sformatf("%s.%0d.ferr", tag, s), 32'(ferr[s]), 32'(m_ferr[s]));
    chk($sformatf("%s.%0d.ovr", tag, s), 32'(ovr[s]), 32'(m_ovr[s]));
    chk($sformatf("%s.%0d.busy", tag, s), 32'(bsy[s]), 32'd0);
  endtask

  task automatic ack(input int s, input string tag);
    clr[s] = 1'b1;
    cyc(1);
    clr[s] = 1'b0;
    m_rdy[s]  = 1'b0;
    m_perr[s] = 1'b0;
    m_ferr[s] = 1'b0;
    m_ovr[s]  = 1'b0;
    check_model(s, tag);
  endtask

  // Send one frame bit-serially; clr_at > 0 pulses the ack so that it is
  // sampled on that cycle count after the start bit begins.
  task automatic send(input int s, input logic [7:0] d, input logic pbit,
                      input logic [1:0] stops, input int clr_at, input string tag);
    logic bits [16];
    int   nb;
    int   rise;
    logic old_rdy;
    int   last;
    nb = 0;
    bits[nb++] = 1'b0;
    for (int i = 0; i < 8; i++) bits[nb++] = d[i];
    if (has_par(s) != 0) bits[nb++] = pbit;
    for (int k = 0; k < n_stop(s); k++) bits[nb++] = stops[k];
    old_rdy = rdy[s];
    rise    = -1;
    last    = nb * BD + 8;
    rx[s]   = bits[0];
    clr[s]  = (clr_at == 1);
    for (int c = 1; c <= last; c++) begin
      @(posedge clk);
      #1;
      if (rise < 0 && !old_rdy && rdy[s]) rise = c;
      rx[s]  = (c / BD < nb) ? bits[c / BD] : 1'b1;
      clr[s] = (clr_at == c + 1);
    end
    clr[s] = 1'b0;
    if (!old_rdy) chk($sformatf("%s.%0d.latency", tag, s), 32'(rise), 32'(latency(s)));
    m_ovr[s]  = (clr_at != 0) ? 1'b0 : (m_ovr[s] | m_rdy[s]);
    m_data[s] = d;
    m_rdy[s]  = 1'b1;
    m_perr[s] = (has_par(s) != 0) && (pbit != ^d);
    m_ferr[s] = 1'b0;
    for (int k = 0; k < n_stop(s); k++) if (stops[k] == 1'b0) m_ferr[s] = 1'b1;
    check_model(s, tag);
  endtask

  initial begin
    logic saw_busy;
    rx[0] = 1'b1; rx[1] = 1'b1;
    clr[0] = 1'b0; clr[1] = 1'b0;
    model_reset();
    rst_n = 1'b0;
    cyc(3);
    check_model(0, "reset");
    check_model(1, "reset");
    rst_n = 1'b1;
    cyc(2);

    send(0, 8'hA5, 1'b0, 2'b11, 0, "8n1_a5");
    ack(0, "ack1");

    send(1, 8'h07, 1'b0, 2'b11, 0, "even_bad");
    ack(1, "ack2");
    send(1, 8'h07, 1'b1, 2'b11, 0, "even_good");
    ack(1, "ack3");

    // Short low pulse: start bit rejected at the half-bit check.
    saw_busy = 1'b0;
    rx[0] = 1'b0;
    for (int c = 1; c <= 40; c++) begin
      cyc(1);
      if (bsy[0]) saw_busy = 1'b1;
      rx[0] = (c < 5) ? 1'b0 : 1'b1;
    end
    chk("glitch.busy_seen", 32'(saw_busy), 32'd1);
    check_model(0, "glitch");

    send(0, 8'h3C, 1'b0, 2'b00, 0, "stop_low");
    ack(0, "ack4");

    send(0, 8'h11, 1'b0, 2'b11, 0, "ovr_first");
    send(0, 8'h22, 1'b0, 2'b11, 0, "ovr_second");
    ack(0, "ack5");

    // Abort a frame part-way with reset.
    rx[0] = 1'b0;
    cyc(40);
    rst_n = 1'b0;
    rx[0] = 1'b1;
    cyc(3);
    model_reset();
    chk("midrst.busy", 32'(bsy[0]), 32'd0);
    rst_n = 1'b1;
    cyc(5);
    check_model(0, "midrst");
    send(0, 8'h5A, 1'b0, 2'b11, latency(0), "after_rst");

    // Random frames: random data, parity and stop correctness, acks.
    for (int i = 0; i < 24; i++) begin
      int         s;
      logic [7:0] d;
      logic       pbit;
      logic [1:0] stops;
      int         clr_at;
      s     = int'($urandom_range(0, 1));
      d     = 8'($urandom);
      pbit  = ($urandom_range(0, 1) == 1) ? ^d : 1'($urandom_range(0, 1));
      stops = 2'b11;
      if ($urandom_range(0, 4) == 0) stops = 2'($urandom_range(0, 2));
      if ($urandom_range(0, 2) == 0) ack(s, $sformatf("rack%0d", i));
      clr_at = ($urandom_range(0, 3) == 0) ? latency(s) : 0;
      cyc(int'($urandom_range(0, 5)));
      send(s, d, pbit, stops, clr_at, $sformatf("rnd%0d", i));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
